ib_fifo_sub: RTL and testbench

//  Per-port input buffer FIFO that sits directly upstream of the routing-compute stage.
//  - Accepts flits from a link or a local core and stores up to DEPTH flits.
//  - Presents the head flit with a valid flag to routing compute and pops it when ready is high.
//  - Exports its occupancy as the pressure value that neighbouring routers use for adaptive routing.

---
 rtl/ib_fifo_sub.sv | 87 ++++++++
 tb/tb_ib_fifo_sub.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/ib_fifo_sub.sv
// Per-port input buffer FIFO with first-word fall-through head and occupancy pressure.
// Optional rejected-push counter enabled by defining IB_DROP_CNT_EN.
module ib_fifo_sub #(
   parameter int DEPTH    = 8,
   parameter int WIDTH    = 3,
   parameter int DATASIZE = 40
) (
   input  logic                ib_clk,
   input  logic                rst,
   input  logic [DATASIZE-1:0] data_in,
   input  logic                valid_in,
   output logic                in_ready,
   output logic [DATASIZE-1:0] data_out,
   output logic                valid_out,
   input  logic                rc_ready,
   output logic [WIDTH:0]      pressure_out,
   output logic [7:0]          drop_cnt
);

   localparam logic [WIDTH:0] CNT_FULL = (WIDTH+1)'(DEPTH);

   logic [DATASIZE-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0]    wr_ptr_q, wr_ptr_d;
   logic [WIDTH-1:0]    rd_ptr_q, rd_ptr_d;
   logic [WIDTH:0]      count_q, count_d;
   logic                full, empty, push, pop;

   // Status comes only from the registered count, never from valid_in/rc_ready
   assign full         = (count_q == CNT_FULL);
   assign empty        = (count_q == '0);
   assign in_ready     = !full;
   assign valid_out    = !empty;
   assign pressure_out = count_q;
   assign data_out     = mem_q[rd_ptr_q];

   assign push = valid_in & in_ready;
   assign pop  = valid_out & rc_ready;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      unique case ({push, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge ib_clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage is deliberately not reset; pointers alone define validity
   always_ff @(posedge ib_clk) begin
      if (push) mem_q[wr_ptr_q] <= data_in;
   end

`ifdef IB_DROP_CNT_EN
   logic [7:0] drop_q, drop_d;

   always_comb begin
      drop_d = drop_q;
      if (valid_in && full && (drop_q != 8'hFF)) drop_d = drop_q + 8'd1;
   end

   always_ff @(posedge ib_clk or posedge rst) begin
      if (rst) drop_q <= '0;
      else     drop_q <= drop_d;
   end

   assign drop_cnt = drop_q;
`else
   assign drop_cnt = 8'h00;
`endif

endmodule

// File: tb/tb_ib_fifo_sub.sv
// Bench for ib_fifo_sub: directed steps plus random traffic against a queue model.
module tb_ib_fifo_sub;

   localparam int DEPTH = 8;
   localparam int WIDTH = 3;
   localparam int DS    = 40;

   logic          ib_clk = 1'b0;
   logic          rst;
   logic [DS-1:0] data_in;
   logic          valid_in;
   logic          in_ready;
   logic [DS-1:0] data_out;
   logic          valid_out;
   logic          rc_ready;
   logic [WIDTH:0] pressure_out;
   logic [7:0]    drop_cnt;

   int vectors = 0;
   int miscompares = 0;

   logic [DS-1:0] q[$];
   int drops = 0;

   ib_fifo_sub #(.DEPTH(DEPTH), .WIDTH(WIDTH), .DATASIZE(DS)) dut (
      .ib_clk       (ib_clk),
      .rst          (rst),
      .data_in      (data_in),
      .valid_in     (valid_in),
      .in_ready     (in_ready),
      .data_out     (data_out),
      .valid_out    (valid_out),
      .rc_ready     (rc_ready),
      .pressure_out (pressure_out),
      .drop_cnt     (drop_cnt)
   );

   always #5 ib_clk = ~ib_clk;

   task automatic chk(input string tag, input logic [DS-1:0] obs,
                      input logic [DS-1:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic check_state(input string tag);
      chk({tag, ".in_ready"}, DS'(in_ready), DS'(q.size() < DEPTH));
      chk({tag, ".valid_out"}, DS'(valid_out), DS'(q.size() > 0));
      chk({tag, ".pressure"}, DS'(pressure_out), DS'(q.size()));
      chk({tag, ".drop_cnt"}, DS'(drop_cnt), DS'(drops));
      if (q.size() > 0) chk({tag, ".data_out"}, data_out, q[0]);
   endtask

   function automatic logic [DS-1:0] mk_flit(input logic [3:0] dst);
      logic [DS-1:0] f;
      f[31:0]  = $urandom;
      f[39:32] = 8'($urandom);
      f[35:32] = dst;
      return f;
   endfunction

   // One clock: drive, let the edge happen, update the model, check outputs
   task automatic cycle(input logic vin, input logic [DS-1:0] din,
                        input logic rdy, input string tag);
      bit do_push, do_pop, do_drop;
      valid_in = vin;
      data_in  = din;
      rc_ready = rdy;
      do_push = vin && (q.size() < DEPTH);
      do_pop  = rdy && (q.size() > 0);
      do_drop = vin && (q.size() == DEPTH);
      @(posedge ib_clk);
      #1;
      if (do_pop) void'(q.pop_front());
      if (do_push) q.push_back(din);
`ifdef IB_DROP_CNT_EN
      if (do_drop && drops < 255) drops++;
`else
      if (do_drop) drops = drops;
`endif
      valid_in = 1'b0;
      rc_ready = 1'b0;
      check_state(tag);
   endtask

   initial begin
      logic [DS-1:0] f;
      rst = 1'b1;
      valid_in = 1'b0;
      rc_ready = 1'b0;
      data_in = '0;
      repeat (2) @(posedge ib_clk);
      #1;
      rst = 1'b0;

      // 1: reset then idle
      check_state("reset");
      cycle(1'b0, '0, 1'b0, "idle");

      // 2: three pushes, then three pops
      cycle(1'b1, mk_flit(4'b0001), 1'b0, "push1");
      cycle(1'b1, mk_flit(4'b1001), 1'b0, "push2");
      cycle(1'b1, mk_flit(4'b0100), 1'b0, "push3");
      chk("push3.pressure3", DS'(pressure_out), DS'(3));
      for (int i = 0; i < 3; i++) cycle(1'b0, '0, 1'b1, "pop");
      chk("pop3.empty", DS'(valid_out), DS'(0));
      cycle(1'b0, '0, 1'b1, "pop_empty");

      // 3: fill, then push attempts while full
      for (int i = 0; i < DEPTH; i++) cycle(1'b1, mk_flit(4'(i)), 1'b0, "fill");
      chk("fill.in_ready", DS'(in_ready), DS'(0));
      chk("fill.pressure", DS'(pressure_out), DS'(DEPTH));
      for (int i = 0; i < 3; i++) cycle(1'b1, mk_flit(4'hF), 1'b0, "full_push");
`ifdef IB_DROP_CNT_EN
      chk("drops3", DS'(drop_cnt), DS'(3));
`else
      chk("drops3", DS'(drop_cnt), DS'(0));
`endif

      // 4: full with push+pop, then push+pop at 7
      cycle(1'b1, mk_flit(4'hA), 1'b1, "full_pp");
      chk("full_pp.pressure7", DS'(pressure_out), DS'(DEPTH - 1));
      cycle(1'b1, mk_flit(4'hB), 1'b1, "pp7");
      chk("pp7.pressure7", DS'(pressure_out), DS'(DEPTH - 1));

      // 5: drain, then stream 20 flits across pointer wrap
      while (q.size() > 0) cycle(1'b0, '0, 1'b1, "drain");
      for (int i = 0; i < 20; i++) cycle(1'b1, mk_flit(4'(i)), 1'b1, "stream");
      cycle(1'b0, '0, 1'b1, "stream_tail");

      // Random traffic
      for (int i = 0; i < 300; i++)
         cycle(1'(($urandom_range(0, 3) != 0)), mk_flit(4'($urandom)),
               1'(($urandom_range(0, 2) != 0)), "rand");

      // 6: async reset with 5 flits buffered
      while (q.size() > 0) cycle(1'b0, '0, 1'b1, "drain2");
      for (int i = 0; i < 5; i++) cycle(1'b1, mk_flit(4'(i)), 1'b0, "pre_rst");
      #2;
      rst = 1'b1;
      #1;
      q.delete();
      drops = 0;
      chk("async_rst.valid_out", DS'(valid_out), DS'(0));
      chk("async_rst.pressure", DS'(pressure_out), DS'(0));
      chk("async_rst.in_ready", DS'(in_ready), DS'(1));
      chk("async_rst.drop_cnt", DS'(drop_cnt), DS'(0));
      #8;
      rst = 1'b0;
      check_state("post_rst");
      f = mk_flit(4'h7);
      cycle(1'b1, f, 1'b0, "post_rst_push");
      chk("post_rst.readback", data_out, f);
      cycle(1'b0, '0, 1'b1, "post_rst_pop");

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
